// File: rtl/riscv_pkg.sv
// Shared RV64I control definitions: opcodes, funct fields,
// FSM state encoding, immediate formats and instruction classes.
package riscv_pkg;

    localparam logic [6:0] OP_ARIT     = 7'b0110011;
    localparam logic [6:0] OP_ARIT_IMM = 7'b0010011;
    localparam logic [6:0] OP_LOAD     = 7'b0000011;
    localparam logic [6:0] OP_STORE    = 7'b0100011;
    localparam logic [6:0] OP_BRANCH   = 7'b1100011;

    localparam logic [2:0] F3_ADD   = 3'b000;
    localparam logic [2:0] F3_LD_SD = 3'b011;
    localparam logic [2:0] F3_BEQ   = 3'b000;
    localparam logic [2:0] F3_BNE   = 3'b001;
    localparam logic [2:0] F3_BLT   = 3'b100;
    localparam logic [2:0] F3_BGE   = 3'b101;
    localparam logic [2:0] F3_BLTU  = 3'b110;
    localparam logic [2:0] F3_BGEU  = 3'b111;

    localparam logic [6:0] F7_ADD = 7'b0000000;
    localparam logic [6:0] F7_SUB = 7'b0100000;

    localparam logic [2:0] IMM_I = 3'd0;
    localparam logic [2:0] IMM_S = 3'd1;
    localparam logic [2:0] IMM_B = 3'd2;
    localparam logic [2:0] IMM_R = 3'd3;

    typedef enum logic [2:0] {
        BUSCA      = 3'd0,
        DECODIFICA = 3'd1,
        EXECUTA    = 3'd2,
        MEMORIA    = 3'd3,
        ESCRITA    = 3'd4,
        ERRO       = 3'd7
    } estado_t;

    typedef enum logic [2:0] {
        ARIT,
        ARIT_IMM,
        LOAD,
        STORE,
        BRANCH,
        ILEGAL
    } classe_t;

    function automatic logic desvio_tomado(
        input logic [2:0] f3,
        input logic       maior_u,
        input logic       igual,
        input logic       menor
    );
        logic tomado;
        tomado = 1'b0;
        case (f3)
            F3_BEQ:  tomado = igual;
            F3_BNE:  tomado = !igual;
            F3_BLT:  tomado = menor;
            F3_BGE:  tomado = !menor;
            F3_BLTU: tomado = !(maior_u || igual);
            F3_BGEU: tomado = maior_u || igual;
            default: tomado = 1'b0;
        endcase
        return tomado;
    endfunction

endpackage

// File: rtl/decodificador.sv
// Combinational instruction decoder: classifies the IR contents
// and selects the immediate format for the immediate generator.
module decodificador
    import riscv_pkg::*;
(
    input  logic [31:0] instrucao,
    output classe_t     classe,
    output logic [2:0]  tipo_imm,
    output logic        is_sub,
    output logic [2:0]  branch_f3
);

    logic [6:0] opcode;
    logic [2:0] f3;
    logic [6:0] f7;
    logic       unused_campos;

    assign opcode    = instrucao[6:0];
    assign f3        = instrucao[14:12];
    assign f7        = instrucao[31:25];
    assign is_sub    = (f7 == F7_SUB);
    assign branch_f3 = f3;

    // Register and immediate fields are consumed by the datapath only
    assign unused_campos = ^{instrucao[24:15], instrucao[11:7]};

    always_comb begin
        classe   = ILEGAL;
        tipo_imm = IMM_R;
        unique case (1'b1)
            (opcode == OP_ARIT) && (f3 == F3_ADD)
                && ((f7 == F7_ADD) || (f7 == F7_SUB)): begin
                classe   = ARIT;
                tipo_imm = IMM_R;
            end
            (opcode == OP_ARIT_IMM) && (f3 == F3_ADD): begin
                classe   = ARIT_IMM;
                tipo_imm = IMM_I;
            end
            (opcode == OP_LOAD) && (f3 == F3_LD_SD): begin
                classe   = LOAD;
                tipo_imm = IMM_I;
            end
            (opcode == OP_STORE) && (f3 == F3_LD_SD): begin
                classe   = STORE;
                tipo_imm = IMM_S;
            end
            (opcode == OP_BRANCH) && (f3[2:1] != 2'b01): begin
                classe   = BRANCH;
                tipo_imm = IMM_B;
            end
            default: begin
                classe   = ILEGAL;
                tipo_imm = IMM_R;
            end
        endcase
    end

endmodule

// File: rtl/unidade_controle.sv
// Multicycle RV64I control FSM: fetch, decode, execute, memory
// and write-back sequencing plus branch resolution from ULA flags.
module unidade_controle
    import riscv_pkg::*;
#(
    parameter int XLEN = 64
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] instrucao,
    input  logic        flag_maior_u,
    input  logic        flag_igual,
    input  logic        flag_menor,
    input  logic        mem_pronto,
    output logic        mem_req,
    output logic        mem_we,
    output logic        ir_load,
    output logic        pc_load,
    output logic        pc_src,
    output logic        reg_we,
    output logic        mem_para_reg,
    output logic        soma_ou_subtrai,
    output logic        subtraindo,
    output logic        imediato,
    output logic [2:0]  tipo_imm,
    output logic [2:0]  estado,
    output logic        erro
);

    if (XLEN < 32) begin : g_xlen_invalido
        $error("unidade_controle: XLEN must be at least 32");
    end

    estado_t    estado_q;
    estado_t    prox;
    classe_t    classe;
    logic [2:0] tipo_dec;
    logic       is_sub;
    logic [2:0] branch_f3;

    decodificador u_dec (
        .instrucao (instrucao),
        .classe    (classe),
        .tipo_imm  (tipo_dec),
        .is_sub    (is_sub),
        .branch_f3 (branch_f3)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) estado_q <= BUSCA;
        else        estado_q <= prox;
    end

    // Outputs stay low for the whole reset window, not just after the edge
    always_comb begin
        prox            = estado_q;
        mem_req         = 1'b0;
        mem_we          = 1'b0;
        ir_load         = 1'b0;
        pc_load         = 1'b0;
        pc_src          = 1'b0;
        reg_we          = 1'b0;
        mem_para_reg    = 1'b0;
        soma_ou_subtrai = 1'b0;
        subtraindo      = 1'b0;
        imediato        = 1'b0;
        tipo_imm        = IMM_I;
        estado          = 3'd0;
        erro            = 1'b0;
        if (rst_n) begin
            estado = estado_q;
            case (estado_q)
                BUSCA: begin
                    mem_req = 1'b1;
                    if (mem_pronto) begin
                        ir_load = 1'b1;
                        prox    = DECODIFICA;
                    end
                end
                DECODIFICA: begin
                    tipo_imm = tipo_dec;
                    prox     = (classe == ILEGAL) ? ERRO : EXECUTA;
                end
                EXECUTA: begin
                    tipo_imm = tipo_dec;
                    case (classe)
                        ARIT, ARIT_IMM: begin
                            soma_ou_subtrai = 1'b1;
                            subtraindo      = (classe == ARIT) && is_sub;
                            imediato        = (classe == ARIT_IMM);
                            reg_we          = 1'b1;
                            pc_load         = 1'b1;
                            prox            = BUSCA;
                        end
                        BRANCH: begin
                            pc_load = 1'b1;
                            pc_src  = desvio_tomado(branch_f3, flag_maior_u,
                                                    flag_igual, flag_menor);
                            prox    = BUSCA;
                        end
                        LOAD, STORE: begin
                            soma_ou_subtrai = 1'b1;
                            imediato        = 1'b1;
                            prox            = MEMORIA;
                        end
                        default: prox = ERRO;
                    endcase
                end
                MEMORIA: begin
                    tipo_imm        = tipo_dec;
                    soma_ou_subtrai = 1'b1;
                    imediato        = 1'b1;
                    mem_req         = 1'b1;
                    mem_we          = (classe == STORE);
                    if (mem_pronto) begin
                        if (classe == STORE) begin
                            pc_load = 1'b1;
                            prox    = BUSCA;
                        end else begin
                            prox = ESCRITA;
                        end
                    end
                end
                ESCRITA: begin
                    tipo_imm     = tipo_dec;
                    reg_we       = 1'b1;
                    mem_para_reg = 1'b1;
                    pc_load      = 1'b1;
                    prox         = BUSCA;
                end
                ERRO: begin
                    erro = 1'b1;
                    prox = ERRO;
                end
                default: prox = ERRO;
            endcase
        end
    end

endmodule

// File: tb/tb_unidade_controle.sv
// Directed self-checking bench for the multicycle control unit.
module tb_unidade_controle;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] instrucao = 32'h0;
    logic        flag_maior_u = 1'b0;
    logic        flag_igual = 1'b0;
    logic        flag_menor = 1'b0;
    logic        mem_pronto = 1'b0;
    logic        mem_req, mem_we, ir_load, pc_load, pc_src;
    logic        reg_we, mem_para_reg;
    logic        soma_ou_subtrai, subtraindo, imediato;
    logic [2:0]  tipo_imm, estado;
    logic        erro;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    unidade_controle #(.XLEN(64)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .instrucao       (instrucao),
        .flag_maior_u    (flag_maior_u),
        .flag_igual      (flag_igual),
        .flag_menor      (flag_menor),
        .mem_pronto      (mem_pronto),
        .mem_req         (mem_req),
        .mem_we          (mem_we),
        .ir_load         (ir_load),
        .pc_load         (pc_load),
        .pc_src          (pc_src),
        .reg_we          (reg_we),
        .mem_para_reg    (mem_para_reg),
        .soma_ou_subtrai (soma_ou_subtrai),
        .subtraindo      (subtraindo),
        .imediato        (imediato),
        .tipo_imm        (tipo_imm),
        .estado          (estado),
        .erro            (erro)
    );

    // {req,we,ir_load,pc_load,pc_src,reg_we,m2r,sos,sub,imm,tipo_imm,estado,erro}
    logic [16:0] outs;
    assign outs = {mem_req, mem_we, ir_load, pc_load, pc_src, reg_we,
                   mem_para_reg, soma_ou_subtrai, subtraindo, imediato,
                   tipo_imm, estado, erro};

    function automatic logic [16:0] ov(
        input logic rq, we, il, pl, ps, rw, mr, so, sb, im,
        input logic [2:0] ti, es,
        input logic er
    );
        return {rq, we, il, pl, ps, rw, mr, so, sb, im, ti, es, er};
    endfunction

    task automatic test_reset;
        rst_n      = 1'b0;
        mem_pronto = 1'b1;
        instrucao  = 32'h402081B3;
        for (int i = 0; i < 2; i++) begin
            #1;
            vectors++;
            if (outs !== 17'h0) begin
                $display("FAIL reset cycle %0d: got %h, expected %h",
                         i, outs, 17'h0);
                miscompares++;
            end
            @(posedge clk); #1;
        end
        rst_n = 1'b1;
        #1;
        vectors++;
        if (outs !== ov(1,0,1,0,0,0,0,0,0,0,3'd0,3'd0,0)) begin
            $display("FAIL reset release: got %h, expected %h",
                     outs, ov(1,0,1,0,0,0,0,0,0,0,3'd0,3'd0,0));
            miscompares++;
        end
        mem_pronto = 1'b0;
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic test_arit;
        logic [31:0] ins [3];
        logic [16:0] ex [3][4];
        logic        mp [4];
        ins = '{32'h002081B3, 32'h402081B3, 32'h00500093};
        mp  = '{1'b1, 1'b0, 1'b0, 1'b0};
        ex[0] = '{ov(1,0,1,0,0,0,0,0,0,0,3'd0,3'd0,0),
                  ov(0,0,0,0,0,0,0,0,0,0,3'd3,3'd1,0),
                  ov(0,0,0,1,0,1,0,1,0,0,3'd3,3'd2,0),
                  ov(1,0,0,0,0,0,0,0,0,0,3'd0,3'd0,0)};
        ex[1] = '{ov(1,0,1,0,0,0,0,0,0,0,3'd0,3'd0,0),
                  ov(0,0,0,0,0,0,0,0,0,0,3'd3,3'd1,0),
                  ov(0,0,0,1,0,1,0,1,1,0,3'd3,3'd2,0),
                  ov(1,0,0,0,0,0,0,0,0,0,3'd0,3'd0,0)};
        ex[2] = '{ov(1,0,1,0,0,0,0,0,0,0,3'd0,3'd0,0),
                  ov(0,0,0,0,0,0,0,0,0,0,3'd0,3'd1,0),
                  ov(0,0,0,1,0,1,0,1,0,1,3'd0,3'd2,0),
                  ov(1,0,0,0,0,0,0,0,0,0,3'd0,3'd0,0)};
        for (int j = 0; j < 3; j++) begin
            instrucao = ins[j];
            for (int i = 0; i < 4; i++) begin
                mem_pronto = mp[i];
                #1;
                vectors++;
                if (outs !== ex[j][i]) begin
                    $display("FAIL arit[%0d] cycle %0d: got %h, expected %h",
                             j, i + 1, outs, ex[j][i]);
                    miscompares++;
                end
                @(posedge clk); #1;
            end
        end
    endtask

    task automatic test_ld_wait;
        logic [16:0] ex [8];
        logic        mp [8];
        int          n_reg_we;
        n_reg_we  = 0;
        instrucao = 32'h0080B283;
        mp = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        ex = '{ov(1,0,1,0,0,0,0,0,0,0,3'd0,3'd0,0),
               ov(0,0,0,0,0,0,0,0,0,0,3'd0,3'd1,0),
               ov(0,0,0,0,0,0,0,1,0,1,3'd0,3'd2,0),
               ov(1,0,0,0,0,0,0,1,0,1,3'd0,3'd3,0),
               ov(1,0,0,0,0,0,0,1,0,1,3'd0,3'd3,0),
               ov(1,0,0,0,0,0,0,1,0,1,3'd0,3'd3,0),
               ov(0,0,0,1,0,1,1,0,0,0,3'd0,3'd4,0),
               ov(1,0,0,0,0,0,0,0,0,0,3'd0,3'd0,0)};
        for (int i = 0; i < 8; i++) begin
            mem_pronto = mp[i];
            #1;
            if (reg_we === 1'b1) n_reg_we++;
            vectors++;
            if (outs !== ex[i]) begin
                $display("FAIL ld cycle %0d: got %h, expected %h",
                         i + 1, outs, ex[i]);
                miscompares++;
            end
            @(posedge clk); #1;
        end
        vectors++;
        if (n_reg_we !== 1) begin
            $display("FAIL ld reg_we pulses: got %0d, expected 1", n_reg_we);
            miscompares++;
        end
    endtask

    task automatic test_branch;
        logic [31:0] ins [6];
        logic [2:0]  fl [6];
        logic        tk [6];
        logic [16:0] ex [4];
        logic        mp [4];
        // fl = {maior_u, igual, menor}
        ins = '{32'h0020E863, 32'h0020D863, 32'h00209863,
                32'h0020C863, 32'h0020F863, 32'h00208863};
        fl  = '{3'b000, 3'b001, 3'b010, 3'b001, 3'b010, 3'b000};
        tk  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        mp  = '{1'b1, 1'b0, 1'b0, 1'b0};
        for (int j = 0; j < 6; j++) begin
            instrucao = ins[j];
            {flag_maior_u, flag_igual, flag_menor} = fl[j];
            ex = '{ov(1,0,1,0,0,0,0,0,0,0,3'd0,3'd0,0),
                   ov(0,0,0,0,0,0,0,0,0,0,3'd2,3'd1,0),
                   ov(0,0,0,1,tk[j],0,0,0,0,0,3'd2,3'd2,0),
                   ov(1,0,0,0,0,0,0,0,0,0,3'd0,3'd0,0)};
            for (int i = 0; i < 4; i++) begin
                mem_pronto = mp[i];
                #1;
                vectors++;
                if (outs !== ex[i]) begin
                    $display("FAIL branch[%0d] cycle %0d: got %h, expected %h",
                             j, i + 1, outs, ex[i]);
                    miscompares++;
                end
                @(posedge clk); #1;
            end
        end
        {flag_maior_u, flag_igual, flag_menor} = 3'b000;
    endtask

    task automatic test_sd;
        logic [16:0] ex [5];
        logic        mp [5];
        instrucao = 32'h0020B823;
        mp = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        ex = '{ov(1,0,1,0,0,0,0,0,0,0,3'd0,3'd0,0),
               ov(0,0,0,0,0,0,0,0,0,0,3'd1,3'd1,0),
               ov(0,0,0,0,0,0,0,1,0,1,3'd1,3'd2,0),
               ov(1,1,0,1,0,0,0,1,0,1,3'd1,3'd3,0),
               ov(1,0,0,0,0,0,0,0,0,0,3'd0,3'd0,0)};
        for (int i = 0; i < 5; i++) begin
            mem_pronto = mp[i];
            #1;
            vectors++;
            if (outs !== ex[i]) begin
                $display("FAIL sd cycle %0d: got %h, expected %h",
                         i + 1, outs, ex[i]);
                miscompares++;
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_illegal;
        instrucao  = 32'h0000007F;
        mem_pronto = 1'b1;
        #1;
        vectors++;
        if (outs !== ov(1,0,1,0,0,0,0,0,0,0,3'd0,3'd0,0)) begin
            $display("FAIL illegal fetch: got %h, expected %h",
                     outs, ov(1,0,1,0,0,0,0,0,0,0,3'd0,3'd0,0));
            miscompares++;
        end
        @(posedge clk); #1;
        mem_pronto = 1'b0;
        #1;
        vectors++;
        if (outs !== ov(0,0,0,0,0,0,0,0,0,0,3'd3,3'd1,0)) begin
            $display("FAIL illegal decode: got %h, expected %h",
                     outs, ov(0,0,0,0,0,0,0,0,0,0,3'd3,3'd1,0));
            miscompares++;
        end
        @(posedge clk); #1;
        for (int i = 0; i < 10; i++) begin
            mem_pronto = i[0];
            {flag_maior_u, flag_igual, flag_menor} = 3'(i);
            #1;
            vectors++;
            if (outs !== ov(0,0,0,0,0,0,0,0,0,0,3'd0,3'd7,1)) begin
                $display("FAIL illegal erro cycle %0d: got %h, expected %h",
                         i, outs, ov(0,0,0,0,0,0,0,0,0,0,3'd0,3'd7,1));
                miscompares++;
            end
            @(posedge clk); #1;
        end
        {flag_maior_u, flag_igual, flag_menor} = 3'b000;
        rst_n      = 1'b0;
        mem_pronto = 1'b0;
        #1;
        vectors++;
        if (outs !== 17'h0) begin
            $display("FAIL illegal in reset: got %h, expected %h", outs, 17'h0);
            miscompares++;
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        #1;
        vectors++;
        if (outs !== ov(1,0,0,0,0,0,0,0,0,0,3'd0,3'd0,0)) begin
            $display("FAIL illegal cleared: got %h, expected %h",
                     outs, ov(1,0,0,0,0,0,0,0,0,0,3'd0,3'd0,0));
            miscompares++;
        end
        @(posedge clk); #1;
    endtask

    task automatic test_sd_reset;
        logic [16:0] ex [5];
        logic        mp [5];
        instrucao = 32'h0020B823;
        mp = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        ex = '{ov(1,0,1,0,0,0,0,0,0,0,3'd0,3'd0,0),
               ov(0,0,0,0,0,0,0,0,0,0,3'd1,3'd1,0),
               ov(0,0,0,0,0,0,0,1,0,1,3'd1,3'd2,0),
               ov(1,1,0,0,0,0,0,1,0,1,3'd1,3'd3,0),
               ov(1,1,0,0,0,0,0,1,0,1,3'd1,3'd3,0)};
        for (int i = 0; i < 5; i++) begin
            mem_pronto = mp[i];
            #1;
            vectors++;
            if (outs !== ex[i]) begin
                $display("FAIL sd_reset cycle %0d: got %h, expected %h",
                         i + 1, outs, ex[i]);
                miscompares++;
            end
            @(posedge clk); #1;
        end
        rst_n      = 1'b0;
        mem_pronto = 1'b1;
        #1;
        vectors++;
        if (outs !== 17'h0) begin
            $display("FAIL sd_reset abandon: got %h, expected %h", outs, 17'h0);
            miscompares++;
        end
        @(posedge clk); #1;
        rst_n      = 1'b1;
        mem_pronto = 1'b0;
        #1;
        vectors++;
        if (outs !== ov(1,0,0,0,0,0,0,0,0,0,3'd0,3'd0,0)) begin
            $display("FAIL sd_reset refetch: got %h, expected %h",
                     outs, ov(1,0,0,0,0,0,0,0,0,0,3'd0,3'd0,0));
            miscompares++;
        end
        @(posedge clk); #1;
    endtask

    initial begin
        test_reset();
        test_arit();
        test_ld_wait();
        test_branch();
        test_sd();
        test_illegal();
        test_sd_reset();
        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/unidade_controle.md
# unidade_controle

Multicycle control unit for the RV64I datapath. It sequences fetch, decode, execute, memory and write-back for each instruction, and drives the ULA control inputs `soma_ou_subtrai`, `subtraindo` and `imediato`. It consumes the ULA flags `flag_maior_u`, `flag_igual` and `flag_menor` to resolve branches. It sits directly upstream of the ULA and the register file and handshakes with the unified instruction/data memory.

## Interface
Parameters:
- `XLEN`, 64: datapath width. Documentation only; no port depends on it.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  reset, synchronous, active-low.
- `instrucao`  in  32  current instruction from the external IR. Stable from the cycle after `ir_load` until the next `ir_load`.
- `flag_maior_u`, `flag_igual`, `flag_menor`  in  1 each  ULA comparison flags for rs1 vs rs2.
- `mem_pronto`  in  1  memory acknowledge for the current `mem_req`.
- `mem_req`  out  1  memory access request.
- `mem_we`  out  1  store when 1, read when 0. Meaningful only with `mem_req`.
- `ir_load`  out  1  load the IR from memory read data.
- `pc_load`  out  1  update the PC.
- `pc_src`  out  1  PC source: 0 = PC+4, 1 = PC+imm.
- `reg_we`  out  1  register-file write enable for rd.
- `mem_para_reg`  out  1  write-back source: 1 = memory data, 0 = ULA `dout`.
- `soma_ou_subtrai`, `subtraindo`, `imediato`  out  1 each  ULA controls.
- `tipo_imm`  out  3  immediate-generator format: 0 = I, 1 = S, 2 = B, 3 = R/none.
- `estado`  out  3  current state encoding, for debug.
- `erro`  out  1  illegal instruction seen; sticky until reset.

## Operation
- **Legal instructions:**
  - `add` (opcode 0110011, f3 000, f7 0000000)
  - `sub` (f7 0100000)
  - `addi` (0010011, f3 000)
  - `ld` (0000011, f3 011)
  - `sd` (0100011, f3 011)
  - branches (1100011): `beq` 000, `bne` 001, `blt` 100, `bge` 101, `bltu` 110, `bgeu` 111
  - Anything else is illegal.
- **States:** BUSCA = 0, DECODIFICA = 1, EXECUTA = 2, MEMORIA = 3, ESCRITA = 4, ERRO = 7.
- **Output style:** Moore-style state register; outputs are combinational from state, decoded `instrucao`, flags and `mem_pronto`. Every output not listed for a state is 0.
- **BUSCA:**
  - Drives `mem_req=1`, `mem_we=0`.
  - On `mem_pronto`: `ir_load=1`, go to DECODIFICA. Otherwise stay.
- **DECODIFICA:**
  - No side effects. `tipo_imm` is valid from this state on.
  - Illegal instruction: go to ERRO. Otherwise go to EXECUTA.
- **EXECUTA:**
  - `add`/`addi`/`sub`: `soma_ou_subtrai=1`, `subtraindo` = (sub), `imediato` = (addi), `reg_we=1`, `pc_load=1`, `pc_src=0`, go to BUSCA.
  - Branch: `pc_load=1`, `pc_src` = taken, go to BUSCA.
  - `ld`/`sd`: `soma_ou_subtrai=1`, `subtraindo=0`, `imediato=1`, go to MEMORIA.
- **Branch taken conditions:**
  - `beq`: `flag_igual`
  - `bne`: not `flag_igual`
  - `blt`: `flag_menor`
  - `bge`: not `flag_menor`
  - `bltu`: not (`flag_maior_u` or `flag_igual`)
  - `bgeu`: `flag_maior_u` or `flag_igual`
- **MEMORIA:**
  - Holds the EXECUTA ULA controls so the address stays stable. Drives `mem_req=1`, `mem_we` = (sd).
  - On `mem_pronto`, `sd`: `pc_load=1`, `pc_src=0`, go to BUSCA.
  - On `mem_pronto`, `ld`: go to ESCRITA.
  - Otherwise stay.
- **ESCRITA:** `reg_we=1`, `mem_para_reg=1`, `pc_load=1`, `pc_src=0`, go to BUSCA.
- **ERRO:** all control outputs 0, `erro=1`. Stays in ERRO until reset.
- **`mem_pronto` outside BUSCA/MEMORIA:** ignored.

## Timing
- **Reset behaviour:**
  - While `rst_n=0`, every output is forced to 0 (including `mem_req`, `reg_we`, `pc_load`).
  - At the clock edge, the state loads BUSCA and `erro` clears.
  - The first `mem_req` is asserted in the first cycle with `rst_n=1`.
- **Latency with zero-wait memory** (`mem_pronto` high in the request cycle):
  - R/I-type and branch: 3 cycles.
  - `sd`: 4 cycles.
  - `ld`: 5 cycles.
  - Each wait cycle adds one.
- **Handshake:** `mem_req` and `mem_we` stay constant while waiting. Exactly one cycle of `ir_load`, and one cycle of `pc_load`, per instruction.
- **Reset mid-operation** (any state, including a pending MEMORIA store): the access is abandoned and no `reg_we`/`pc_load` pulse occurs.
- **Flags:** sampled only in EXECUTA.

## Structure
- **Shared package `riscv_pkg`:**
  - opcode, funct3 and funct7 constants
  - state encoding
  - `tipo_imm` encoding
  - instruction-class enum: ARIT, ARIT_IMM, LOAD, STORE, BRANCH, ILEGAL
- **Sub-module `decodificador`:** combinational. Maps `instrucao` to class, `tipo_imm`, `is_sub` and `branch_f3`. `unidade_controle` holds the FSM and branch resolution.

## Test plan
- **Reset:** `rst_n=0` for 2 cycles, then release with `mem_pronto=1` -> cycle 1 `mem_req=1`, `mem_we=0`, `estado=0`; all outputs 0 during reset.
- **`sub x3,x1,x2` (0x402081B3), zero-wait:** EXECUTA shows `soma_ou_subtrai=1`, `subtraindo=1`, `imediato=0`, `reg_we=1`, `pc_load=1`, `pc_src=0`; back in BUSCA on cycle 4.
- **`ld`, memory acks after 2 wait cycles in MEMORIA:** `mem_req` held for 3 cycles with `imediato=1`; ESCRITA has `reg_we=1`, `mem_para_reg=1`; exactly one `reg_we` pulse.
- **Branches:**
  - `bltu` with `flag_maior_u=0`, `flag_igual=0` -> `pc_src=1`.
  - `bge` with `flag_menor=1` -> `pc_src=0`.
  - `bne` with `flag_igual=1` -> `pc_src=0`.
- **Illegal opcode 0x0000007F** -> ERRO after DECODIFICA, `erro=1` and all enables 0 for 10 cycles; `rst_n` pulse clears it.
- **`sd` with `rst_n` dropped in MEMORIA before `mem_pronto`** -> no `pc_load`; state BUSCA after the reset edge.
